// File: rtl/datapath_pipe.sv
// Register file with bypassed async reads, ALU with optional immediate operand,
// one-entry writeback stage and registered zero/carry flags.
module datapath_pipe #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_en,
    input  logic [2:0]            alu_opcode,
    input  logic                  imm_en,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] user_write_data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] ra_addr,
    input  logic [ADDR_WIDTH-1:0] rb_addr,
    output logic [DATA_WIDTH-1:0] read_a,
    output logic [DATA_WIDTH-1:0] read_b,
    output logic                  alu_zero,
    output logic                  alu_carry,
    output logic                  wb_busy
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    logic                  wb_valid;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_c;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   diff;

    // Bypassed reads: a pending writeback wins over the array, register 0 may be hardwired
    always_comb begin
        read_a = regs[ra_addr];
        if (ZERO_REG && (ra_addr == '0)) begin
            read_a = '0;
        end else if (wb_valid && (wb_addr == ra_addr)) begin
            read_a = wb_data;
        end
        read_b = regs[rb_addr];
        if (ZERO_REG && (rb_addr == '0)) begin
            read_b = '0;
        end else if (wb_valid && (wb_addr == rb_addr)) begin
            read_b = wb_data;
        end
    end

    // ALU; sum/diff carry one extra bit for carry-out and borrow
    always_comb begin
        op_b       = imm_en ? imm : read_b;
        sum        = {1'b0, read_a} + {1'b0, op_b};
        diff       = {1'b0, read_a} - {1'b0, op_b};
        alu_result = '0;
        alu_c      = 1'b0;
        case (alu_opcode)
            OP_ADD: begin
                alu_result = sum[DATA_WIDTH-1:0];
                alu_c      = sum[DATA_WIDTH];
            end
            OP_SUB: begin
                alu_result = diff[DATA_WIDTH-1:0];
                alu_c      = diff[DATA_WIDTH];
            end
            OP_AND: alu_result = read_a & op_b;
            OP_OR:  alu_result = read_a | op_b;
            OP_XOR: alu_result = read_a ^ op_b;
            OP_NOT: alu_result = ~read_a;
            OP_SHL: begin
                alu_result = {read_a[DATA_WIDTH-2:0], 1'b0};
                alu_c      = read_a[DATA_WIDTH-1];
            end
            OP_SHR: begin
                alu_result = {1'b0, read_a[DATA_WIDTH-1:1]};
                alu_c      = read_a[0];
            end
            default: begin
                alu_result = '0;
                alu_c      = 1'b0;
            end
        endcase
    end

    // Capture stage and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            alu_zero  <= 1'b0;
            alu_carry <= 1'b0;
        end else begin
            wb_valid <= write_en;
            if (write_en) begin
                wb_addr <= write_addr;
                wb_data <= alu_en ? alu_result : user_write_data;
                if (alu_en) begin
                    alu_zero  <= (alu_result == '0);
                    alu_carry <= alu_c;
                end
            end
        end
    end

    // Commit stage; reset drops any pending writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_valid && !(ZERO_REG && (wb_addr == '0))) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign wb_busy = wb_valid;

endmodule

// File: tb/tb_datapath_pipe.sv
// Checks a ZERO_REG=1 and a ZERO_REG=0 instance against an architectural model in
// which a captured write is visible on the read ports from the next cycle onward.
module tb_datapath_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       alu_en;
    logic [2:0] alu_opcode;
    logic       imm_en;
    logic [7:0] imm;
    logic [7:0] user_write_data;
    logic [3:0] write_addr;
    logic       write_en;
    logic [3:0] ra_addr;
    logic [3:0] rb_addr;

    logic [7:0] rd_a1, rd_b1, rd_a0, rd_b0;
    logic       z1, c1, busy1, z0, c0, busy0;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Model: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance
    logic [7:0] m [2][16];
    logic       mz [2];
    logic       mc [2];
    logic       mb;

    always #5 clk = ~clk;

    datapath_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(1'b1)) u_z1 (
        .clk(clk), .rst(rst), .alu_en(alu_en), .alu_opcode(alu_opcode),
        .imm_en(imm_en), .imm(imm), .user_write_data(user_write_data),
        .write_addr(write_addr), .write_en(write_en), .ra_addr(ra_addr),
        .rb_addr(rb_addr), .read_a(rd_a1), .read_b(rd_b1), .alu_zero(z1),
        .alu_carry(c1), .wb_busy(busy1)
    );

    datapath_pipe #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(1'b0)) u_z0 (
        .clk(clk), .rst(rst), .alu_en(alu_en), .alu_opcode(alu_opcode),
        .imm_en(imm_en), .imm(imm), .user_write_data(user_write_data),
        .write_addr(write_addr), .write_en(write_en), .ra_addr(ra_addr),
        .rb_addr(rb_addr), .read_a(rd_a0), .read_b(rd_b0), .alu_zero(z0),
        .alu_carry(c0), .wb_busy(busy0)
    );

    function automatic logic [7:0] rd(input int k, input logic [3:0] a);
        return (k == 0 && a == 4'd0) ? 8'h00 : m[k][a];
    endfunction

    // Reference ALU from plain integer arithmetic
    function automatic void alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] r, output logic c);
        int s;
        c = 1'b0;
        case (op)
            3'd0: begin s = int'(a) + int'(b); r = 8'(s); c = (s > 255); end
            3'd1: begin s = int'(a) - int'(b); r = 8'(s + 256); c = (int'(a) < int'(b)); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = ~a;
            3'd6: begin r = 8'((int'(a) * 2) % 256); c = (int'(a) >= 128); end
            default: begin r = 8'(int'(a) / 2); c = (int'(a) % 2 == 1); end
        endcase
    endfunction

    task automatic model_step();
        logic [7:0] a, b, r, v;
        logic       c;
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < 16; i++) m[k][i] = 8'h00;
                mz[k] = 1'b0;
                mc[k] = 1'b0;
            end
            mb = 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                a = rd(k, ra_addr);
                b = imm_en ? imm : rd(k, rb_addr);
                alu(alu_opcode, a, b, r, c);
                if (write_en) begin
                    if (alu_en) begin
                        mz[k] = (r == 8'h00);
                        mc[k] = c;
                    end
                    v = alu_en ? r : user_write_data;
                    if (!(k == 0 && write_addr == 4'd0)) m[k][write_addr] = v;
                end
            end
            mb = write_en;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%02h expected=%02h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle compare of both instances against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("read_a_z1", rd_a1, rd(0, ra_addr));
            chk("read_b_z1", rd_b1, rd(0, rb_addr));
            chk("zero_z1",   8'(z1), 8'(mz[0]));
            chk("carry_z1",  8'(c1), 8'(mc[0]));
            chk("busy_z1",   8'(busy1), 8'(mb));
            chk("read_a_z0", rd_a0, rd(1, ra_addr));
            chk("read_b_z0", rd_b0, rd(1, rb_addr));
            chk("zero_z0",   8'(z0), 8'(mz[1]));
            chk("carry_z0",  8'(c0), 8'(mc[1]));
            chk("busy_z0",   8'(busy0), 8'(mb));
        end
    end

    task automatic cyc(input logic we, input logic ae, input logic [2:0] op, input logic ie,
                       input logic [7:0] im, input logic [7:0] ud, input logic [3:0] wa,
                       input logic [3:0] ra, input logic [3:0] rb);
        write_en = we; alu_en = ae; alu_opcode = op; imm_en = ie; imm = im;
        user_write_data = ud; write_addr = wa; ra_addr = ra; rb_addr = rb;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 4'd0, ra_addr, rb_addr);
    endtask

    task automatic wr(input logic [3:0] wa, input logic [7:0] d);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 8'h00, d, wa, 4'd0, 4'd0);
    endtask

    task automatic peek_a(input logic [3:0] a);
        ra_addr = a;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        write_en = 1'b0; alu_en = 1'b0; alu_opcode = 3'd0; imm_en = 1'b0; imm = 8'h00;
        user_write_data = 8'h00; write_addr = 4'd0; ra_addr = 4'd0; rb_addr = 4'd0;
        idle();
        idle();
        rst = 1'b0;
        chk_on = 1'b1;
        peek_a(4'd5);
        chk("lit_reset_r5", rd_a1, 8'h00);
        chk("lit_reset_busy", 8'(busy1), 8'h00);

        // Fill r0..r15 with i*0x11 and sweep both ports in opposite directions
        for (int i = 0; i < 16; i++) wr(4'(i), 8'(i * 17));
        for (int i = 0; i < 16; i++)
            cyc(1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 8'h00, 4'd0, 4'(i), 4'(15 - i));
        peek_a(4'd5);
        chk("lit_fill_r5", rd_a1, 8'h55);
        peek_a(4'd0);
        chk("lit_fill_r0", rd_a1, 8'h00);

        // Dependent ADD chain, one per cycle
        wr(4'd1, 8'h00);
        wr(4'd2, 8'h01);
        for (int i = 0; i < 64; i++)
            cyc(1'b1, 1'b1, 3'd0, 1'b0, 8'h00, 8'h00, 4'd1, 4'd1, 4'd2);
        peek_a(4'd1);
        chk("lit_add_chain", rd_a1, 8'h40);

        // SUB with borrow: 0x7F minus 0x0A thirteen times wraps on the last step
        wr(4'd12, 8'h7F);
        wr(4'd6, 8'h0A);
        cyc(1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 4'd12, 4'd12, 4'd6);
        peek_a(4'd12);
        chk("lit_sub_first", rd_a1, 8'h75);
        chk("lit_sub_first_c", 8'(c1), 8'h00);
        for (int i = 0; i < 12; i++)
            cyc(1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 8'h00, 4'd12, 4'd12, 4'd6);
        peek_a(4'd12);
        chk("lit_sub_wrap", rd_a1, 8'hFD);
        chk("lit_sub_wrap_c", 8'(c1), 8'h01);

        // Immediate ADD overflow, SHL carry, then a non-writing op leaves flags alone
        wr(4'd3, 8'hFF);
        cyc(1'b1, 1'b1, 3'd0, 1'b1, 8'h01, 8'h00, 4'd3, 4'd3, 4'd0);
        peek_a(4'd3);
        chk("lit_imm_res", rd_a1, 8'h00);
        chk("lit_imm_zero", 8'(z1), 8'h01);
        chk("lit_imm_carry", 8'(c1), 8'h01);
        wr(4'd4, 8'h81);
        cyc(1'b1, 1'b1, 3'd6, 1'b0, 8'h00, 8'h00, 4'd4, 4'd4, 4'd0);
        peek_a(4'd4);
        chk("lit_shl_res", rd_a1, 8'h02);
        chk("lit_shl_carry", 8'(c1), 8'h01);
        cyc(1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 8'h00, 4'd4, 4'd4, 4'd3);
        chk("lit_hold_zero", 8'(z1), 8'h00);
        chk("lit_hold_carry", 8'(c1), 8'h01);

        // Compare-only op targeting r0
        wr(4'd9, 8'h05);
        cyc(1'b1, 1'b1, 3'd0, 1'b1, 8'h00, 8'h00, 4'd0, 4'd9, 4'd0);
        idle();
        peek_a(4'd0);
        chk("lit_r0_zr1", rd_a1, 8'h00);
        chk("lit_r0_zr0", rd_a0, 8'h05);
        chk("lit_r0_zero", 8'(z1), 8'h00);
        chk("lit_r0_carry", 8'(c1), 8'h00);

        // Reset while a write is pending discards it
        wr(4'd7, 8'h5A);
        peek_a(4'd7);
        chk("lit_pend_bypass", rd_a1, 8'h5A);
        chk("lit_pend_busy", 8'(busy1), 8'h01);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        peek_a(4'd7);
        chk("lit_rst_r7", rd_a1, 8'h00);
        chk("lit_rst_busy", 8'(busy1), 8'h00);
        chk("lit_rst_flags", 8'({z1, c1}), 8'h00);
        for (int i = 0; i < 3; i++) idle();
        peek_a(4'd7);
        chk("lit_rst_r7_late", rd_a1, 8'h00);

        // Randomised traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(63) == 0);
            cyc(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 8'($urandom),
                8'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        end
        rst = 1'b0;
        idle();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
